// File: rtl/ofdm_tx_pkg.sv
// ofdm_tx_pkg: shared constants and types for the OFDM transmitter interleaver.
package ofdm_tx_pkg;
  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 8;
  typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-LIMIT counter with enable and terminal-count flag.
module wrap_counter #(
  parameter int LIMIT = 4,
  parameter int W = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(LIMIT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/block_interleaver.sv
// block_interleaver: ping-pong row-in/column-out block interleaver with valid/ready on both sides.
module block_interleaver
  import ofdm_tx_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int N = ROWS * COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  logic [DATA_W-1:0] mem [2][N];
  bank_state_e bank_st [2];
  bank_state_e bank_nx [2];
  logic wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic wr_en, rd_en, wr_tc, r_tc, c_tc, wr_last, rd_last;
  assign wr_en = in_valid && in_ready;
  assign rd_en = out_valid && out_ready;
  assign wr_last = wr_en && wr_tc;
  assign rd_last = rd_en && r_tc && c_tc;
  assign rd_addr = AW'(r) * AW'(COLS) + AW'(c);
  wrap_counter #(.LIMIT(N), .W(AW)) u_wr (
    .clk(clk), .rst(rst), .en(wr_en), .cnt(wr_addr), .tc(wr_tc)
  );
  wrap_counter #(.LIMIT(ROWS), .W(RW)) u_row (
    .clk(clk), .rst(rst), .en(rd_en), .cnt(r), .tc(r_tc)
  );
  // Column advances only when the row counter wraps on an accepted read.
  wrap_counter #(.LIMIT(COLS), .W(CW)) u_col (
    .clk(clk), .rst(rst), .en(rd_en && r_tc), .cnt(c), .tc(c_tc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      bank_st[0] <= bank_nx[0];
      bank_st[1] <= bank_nx[1];
    end
  // A bank cannot be both completed by a write and drained by a read in one cycle.
  always_comb
    for (int b = 0; b < 2; b++)
      bank_nx[b] = (wr_last && wr_bank == 1'(b)) ? BANK_FULL :
                   (rd_last && rd_bank == 1'(b)) ? BANK_EMPTY : bank_st[b];
  always_comb begin
    in_ready = bank_st[wr_bank] == BANK_EMPTY;
    out_valid = bank_st[rd_bank] == BANK_FULL;
    out_data = mem[rd_bank][rd_addr];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_last) wr_bank <= ~wr_bank;
      if (rd_last) rd_bank <= ~rd_bank;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++)
          mem[b][i] <= '0;
    end else if (wr_en) mem[wr_bank][wr_addr] <= in_data;
endmodule
